// File: rtl/i2c_xfer_seq_if.sv
// Request, data-stream and byte-controller command signals of the I2C transfer sequencer.
// The sequencer connects through the slave modport; requester and byte controller use master.
interface i2c_xfer_seq_if #(
  parameter int LEN_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_rnw;
  logic [6:0]       req_dev_addr;
  logic [7:0]       req_reg_addr;
  logic [LEN_W-1:0] req_len;
  logic             wdata_valid;
  logic             wdata_ready;
  logic [7:0]       wdata;
  logic             rdata_valid;
  logic             rdata_ready;
  logic [7:0]       rdata;
  logic             done;
  logic [1:0]       status;
  logic             busy;
  logic             bc_start;
  logic             bc_stop;
  logic             bc_read;
  logic             bc_write;
  logic             bc_ack_in;
  logic [7:0]       bc_din;
  logic             bc_cmd_ack;
  logic             bc_ack_out;
  logic [7:0]       bc_dout;
  logic             bc_al;

  modport slave (
    input  req_valid, req_rnw, req_dev_addr, req_reg_addr, req_len,
    input  wdata_valid, wdata, rdata_ready,
    input  bc_cmd_ack, bc_ack_out, bc_dout, bc_al,
    output req_ready, wdata_ready, rdata_valid, rdata, done, status, busy,
    output bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
  );

  modport master (
    output req_valid, req_rnw, req_dev_addr, req_reg_addr, req_len,
    output wdata_valid, wdata, rdata_ready,
    output bc_cmd_ack, bc_ack_out, bc_dout, bc_al,
    input  req_ready, wdata_ready, rdata_valid, rdata, done, status, busy,
    input  bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
  );
endinterface

// File: rtl/i2c_xfer_seq.sv
// Turns one register transfer request into START/addr/reg/(Sr)/data/STOP byte-controller commands;
// all outputs registered, stalls on wdata/rdata handshakes. I2C_SEQ_TIMEOUT_EN adds a per-command timeout.
module i2c_xfer_seq #(
  parameter int          LEN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input logic           clk,
  input logic           rst_n,
  i2c_xfer_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, DEV_W, REG, WAIT_WD, DATA_W, RSTART, RD, RD_OUT, ERR_STOP, FIN
  } state_t;

  state_t           state, nxt;
  logic [6:0]       dev_q, n_dev;
  logic [7:0]       reg_q, n_reg;
  logic             rnw_q, n_rnw;
  logic [LEN_W-1:0] cnt, n_cnt;
  logic [7:0]       wbyte, n_wbyte;
  logic [7:0]       rbyte, n_rbyte;
  logic [1:0]       n_status;
  logic             n_start, n_stop, n_read, n_write, n_ack_in;
  logic [7:0]       n_din;
  logic             last, in_xfer;

  assign last    = (cnt == LEN_W'(1));
  assign in_xfer = (state != IDLE) && (state != FIN);

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [31:0] tmo;
  logic        cmd_st;

  assign cmd_st = state inside {DEV_W, REG, DATA_W, RSTART, RD, ERR_STOP};

  // Restarts whenever a new command goes out; frozen at zero while waiting on a stream.
  always_ff @(posedge clk) begin
    if (!rst_n || nxt != state || !cmd_st) tmo <= '0;
    else                                   tmo <= tmo + 32'd1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  always_comb begin
    nxt      = state;
    n_dev    = dev_q;
    n_reg    = reg_q;
    n_rnw    = rnw_q;
    n_cnt    = cnt;
    n_wbyte  = wbyte;
    n_rbyte  = rbyte;
    n_status = bus.status;
    case (state)
      IDLE: if (bus.req_valid) begin
        n_dev    = bus.req_dev_addr;
        n_reg    = bus.req_reg_addr;
        n_rnw    = bus.req_rnw;
        n_cnt    = bus.req_len;
        n_status = 2'd0;
        nxt      = DEV_W;
      end
      DEV_W: if (bus.bc_cmd_ack) nxt = bus.bc_ack_out ? ERR_STOP : REG;
      REG: if (bus.bc_cmd_ack) begin
        // A zero-length register write already carried the STOP, so a NACK finishes directly.
        if (cnt == '0) begin
          nxt      = FIN;
          n_status = {1'b0, bus.bc_ack_out};
        end else if (bus.bc_ack_out) nxt = ERR_STOP;
        else                         nxt = rnw_q ? RSTART : WAIT_WD;
      end
      WAIT_WD: if (bus.wdata_valid) begin
        n_wbyte = bus.wdata;
        nxt     = DATA_W;
      end
      DATA_W: if (bus.bc_cmd_ack) begin
        n_cnt = cnt - LEN_W'(1);
        if (last) begin
          nxt      = FIN;
          n_status = {1'b0, bus.bc_ack_out};
        end else nxt = bus.bc_ack_out ? ERR_STOP : WAIT_WD;
      end
      RSTART: if (bus.bc_cmd_ack) nxt = bus.bc_ack_out ? ERR_STOP : RD;
      RD: if (bus.bc_cmd_ack) begin
        n_rbyte = bus.bc_dout;
        n_cnt   = cnt - LEN_W'(1);
        nxt     = RD_OUT;
      end
      RD_OUT: if (bus.rdata_ready) nxt = (cnt == '0) ? FIN : RD;
      ERR_STOP: if (bus.bc_cmd_ack) begin
        nxt      = FIN;
        n_status = 2'd1;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
`ifdef I2C_SEQ_TIMEOUT_EN
    if (cmd_st && !bus.bc_cmd_ack && tmo == TIMEOUT_CYC - 32'd1) begin
      nxt      = FIN;
      n_status = 2'd3;
    end
`endif
    if (in_xfer && bus.bc_al) begin
      nxt      = FIN;
      n_status = 2'd2;
    end

    // Command bits follow the state being entered; they hold until that state sees its ack.
    n_start  = 1'b0;
    n_stop   = 1'b0;
    n_read   = 1'b0;
    n_write  = 1'b0;
    n_ack_in = 1'b0;
    n_din    = 8'h00;
    case (nxt)
      DEV_W: begin
        n_start = 1'b1;
        n_write = 1'b1;
        n_din   = {n_dev, 1'b0};
      end
      REG: begin
        n_write = 1'b1;
        n_stop  = (n_cnt == '0);
        n_din   = n_reg;
      end
      DATA_W: begin
        n_write = 1'b1;
        n_stop  = (n_cnt == LEN_W'(1));
        n_din   = n_wbyte;
      end
      RSTART: begin
        n_start = 1'b1;
        n_write = 1'b1;
        n_din   = {n_dev, 1'b1};
      end
      RD: begin
        n_read   = 1'b1;
        n_ack_in = (n_cnt == LEN_W'(1));
        n_stop   = (n_cnt == LEN_W'(1));
      end
      ERR_STOP: n_stop = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      dev_q           <= '0;
      reg_q           <= '0;
      rnw_q           <= 1'b0;
      cnt             <= '0;
      wbyte           <= '0;
      rbyte           <= '0;
      bus.req_ready   <= 1'b1;
      bus.wdata_ready <= 1'b0;
      bus.rdata_valid <= 1'b0;
      bus.rdata       <= '0;
      bus.done        <= 1'b0;
      bus.status      <= 2'd0;
      bus.busy        <= 1'b0;
      bus.bc_start    <= 1'b0;
      bus.bc_stop     <= 1'b0;
      bus.bc_read     <= 1'b0;
      bus.bc_write    <= 1'b0;
      bus.bc_ack_in   <= 1'b0;
      bus.bc_din      <= '0;
    end else begin
      state           <= nxt;
      dev_q           <= n_dev;
      reg_q           <= n_reg;
      rnw_q           <= n_rnw;
      cnt             <= n_cnt;
      wbyte           <= n_wbyte;
      rbyte           <= n_rbyte;
      bus.req_ready   <= (nxt == IDLE);
      bus.wdata_ready <= (nxt == WAIT_WD);
      bus.rdata_valid <= (nxt == RD_OUT);
      bus.rdata       <= n_rbyte;
      bus.done        <= (nxt == FIN);
      bus.status      <= n_status;
      bus.busy        <= (nxt != IDLE) && (nxt != FIN);
      bus.bc_start    <= n_start;
      bus.bc_stop     <= n_stop;
      bus.bc_read     <= n_read;
      bus.bc_write    <= n_write;
      bus.bc_ack_in   <= n_ack_in;
      bus.bc_din      <= n_din;
    end
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed + randomized bench for i2c_xfer_seq: an inline byte-controller responder and
// stream drivers run once per cycle; expected command lists come from the transfer rules.
module tb_i2c_xfer_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_xfer_seq_if #(.LEN_W(4)) b ();
  i2c_xfer_seq #(.LEN_W(4), .TIMEOUT_CYC(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

  int tests = 0;
  int fails = 0;

  logic [7:0]  wq [16];
  logic [7:0]  rd_bytes [16];
  int          w_idx, w_n, ack_limit, nack_idx, al_idx, n_acked, rwait, rd_used;
  int          wr_seen, viol, stall_left, stall_rd;
  bit          spurious_en, wv_p, wr_p, rv_p, rr_p;
  logic [7:0]  rd_p;
  logic [7:0]  got_q [$];
  logic [12:0] log_q [$];
  logic [12:0] plan [$];
  logic [12:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cmd_on();
    return b.bc_start | b.bc_stop | b.bc_read | b.bc_write;
  endfunction

  // One clock: commit last cycle's handshakes, answer commands, drive the streams.
  task automatic step();
    @(negedge clk);
    if (wv_p && wr_p) w_idx++;
    if (rv_p && rr_p) got_q.push_back(rd_p);
    b.bc_cmd_ack = 1'b0;
    b.bc_al      = 1'b0;
    b.bc_ack_out = 1'b0;
    if (cmd_on()) begin
      if (n_acked < ack_limit) begin
        if (rwait == 0) begin
          b.bc_cmd_ack = 1'b1;
          log_q.push_back({b.bc_start, b.bc_stop, b.bc_read, b.bc_write, b.bc_ack_in,
                           b.bc_write ? b.bc_din : 8'h00});
          if (n_acked == nack_idx) b.bc_ack_out = 1'b1;
          if (n_acked == al_idx)   b.bc_al = 1'b1;
          if (b.bc_read) begin
            b.bc_dout = rd_bytes[rd_used & 15];
            rd_used++;
          end
          n_acked++;
          rwait = $urandom_range(0, 3);
        end else rwait--;
      end
    end else if (spurious_en) b.bc_cmd_ack = 1'b1;
    if (b.wdata_ready) wr_seen++;
    if (b.wdata_ready && cmd_on()) viol++;
    b.wdata_valid = (w_idx < w_n) && ($urandom_range(0, 3) != 0);
    b.wdata       = wq[w_idx & 15];
    if (b.rdata_valid && stall_left > 0) begin
      b.rdata_ready = 1'b0;
      stall_left--;
      if (b.bc_read) stall_rd++;
    end else b.rdata_ready = 1'($urandom_range(0, 1));
    wv_p = b.wdata_valid;
    wr_p = b.wdata_ready;
    rv_p = b.rdata_valid;
    rr_p = b.rdata_ready;
    rd_p = b.rdata;
  endtask

  task automatic start_req(input bit rnw, input logic [6:0] dev, input logic [7:0] ra, input int len);
    b.req_valid    = 1'b1;
    b.req_rnw      = rnw;
    b.req_dev_addr = dev;
    b.req_reg_addr = ra;
    b.req_len      = 4'(len);
    step();
    b.req_valid = 1'b0;
  endtask

  task automatic xfer(input bit rnw, input logic [6:0] dev, input logic [7:0] ra, input int len,
                      input int nack, input int al, input int stall, input string tag);
    bit         done_seen;
    logic [1:0] st;
    int         exp_st, ewn, ern;
    for (int i = 0; i < 16; i++) begin
      wq[i]       = 8'($urandom);
      rd_bytes[i] = 8'($urandom);
    end
    w_idx = 0; w_n = rnw ? 0 : len; ack_limit = 1000; nack_idx = nack; al_idx = al;
    n_acked = 0; rd_used = 0; wr_seen = 0; viol = 0; stall_left = stall; stall_rd = 0;
    got_q.delete(); log_q.delete();
    start_req(rnw, dev, ra, len);
    chk({tag, ".busy_on_accept"}, 32'(b.busy), 32'd1);
    done_seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (b.done) begin
        done_seen = 1'b1;
        break;
      end
      step();
    end
    chk({tag, ".done_seen"}, 32'(done_seen), 32'd1);
    chk({tag, ".busy_at_done"}, 32'(b.busy), 32'd0);
    st = b.status;
    step();
    chk({tag, ".idle_after_done"}, {30'd0, b.req_ready, b.done}, {30'd0, 1'b1, 1'b0});

    // Planned commands for a fully acknowledged transfer, then cut by NACK / arbitration loss.
    plan.delete();
    plan.push_back({5'b10010, dev, 1'b0});
    plan.push_back({1'b0, len == 0, 3'b010, ra});
    if (len > 0 && !rnw)
      for (int i = 0; i < len; i++) plan.push_back({1'b0, i == len - 1, 3'b010, wq[i]});
    if (len > 0 && rnw) begin
      plan.push_back({5'b10010, dev, 1'b1});
      for (int i = 0; i < len; i++) plan.push_back({1'b0, i == len - 1, 2'b10, i == len - 1, 8'h00});
    end
    exp_q.delete(); exp_st = 0; ewn = 0; ern = 0;
    for (int i = 0; i < plan.size(); i++) begin
      exp_q.push_back(plan[i]);
      if (!rnw && i >= 2) ewn++;
      if (i == al) begin
        exp_st = 2;
        break;
      end
      if (plan[i][10]) ern++;
      if (plan[i][9] && i == nack) begin
        exp_st = 1;
        if (!plan[i][11]) exp_q.push_back({5'b01000, 8'h00});
        break;
      end
    end

    chk({tag, ".status"}, 32'(st), 32'(exp_st));
    chk({tag, ".status_held"}, 32'(b.status), 32'(exp_st));
    chk({tag, ".ncmd"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s.cmd%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    chk({tag, ".wdata_used"}, 32'(w_idx), 32'(ewn));
    chk({tag, ".nrdata"}, 32'(got_q.size()), 32'(ern));
    for (int i = 0; i < ern && i < got_q.size(); i++)
      chk($sformatf("%s.rdata%0d", tag, i), 32'(got_q[i]), 32'(rd_bytes[i]));
    chk({tag, ".cmd_while_wait_wd"}, 32'(viol), 32'd0);
    if (ewn == 0) chk({tag, ".no_wdata_ready"}, 32'(wr_seen), 32'd0);
    if (stall > 0) chk({tag, ".no_read_in_stall"}, 32'(stall_rd), 32'd0);
  endtask

  initial begin
    bit found, done_seen;
    int on_cyc;
    rst_n = 1'b0;
    b.req_valid = 1'b0; b.req_rnw = 1'b0; b.req_dev_addr = '0; b.req_reg_addr = '0; b.req_len = '0;
    b.wdata_valid = 1'b0; b.wdata = '0; b.rdata_ready = 1'b0;
    b.bc_cmd_ack = 1'b0; b.bc_ack_out = 1'b0; b.bc_dout = '0; b.bc_al = 1'b0;
    w_idx = 0; w_n = 0; ack_limit = 0; nack_idx = -1; al_idx = -1; n_acked = 0; rwait = 0;
    rd_used = 0; stall_left = 0; spurious_en = 1'b0;
    wv_p = 1'b0; wr_p = 1'b0; rv_p = 1'b0; rr_p = 1'b0; rd_p = '0;
    for (int i = 0; i < 16; i++) begin
      wq[i] = '0;
      rd_bytes[i] = '0;
    end
    repeat (3) step();
    chk("reset.handshake", {27'd0, b.req_ready, b.busy, b.done, b.wdata_ready, b.rdata_valid},
        {27'd0, 5'b10000});
    chk("reset.status", 32'(b.status), 32'd0);
    chk("reset.cmd", {26'd0, b.bc_start, b.bc_stop, b.bc_read, b.bc_write, b.bc_ack_in, b.bc_din == 8'h00},
        {26'd0, 6'b000001});
    rst_n = 1'b1;
    step();

    spurious_en = 1'b1;
    repeat (3) step();
    spurious_en = 1'b0;
    step();
    chk("spurious_ack.idle", {29'd0, b.busy, b.req_ready, cmd_on()}, {29'd0, 3'b010});

    xfer(1'b0, 7'h50, 8'h10, 2,  -1, -1, 0, "wr2");
    xfer(1'b1, 7'h50, 8'h20, 3,  -1, -1, 0, "rd3");
    xfer(1'b1, 7'h50, 8'h20, 3,  -1, -1, 5, "rd3_stall");
    xfer(1'b0, 7'h50, 8'h30, 2,   0, -1, 0, "nack_dev");
    xfer(1'b0, 7'($urandom), 8'($urandom), 3, 3, -1, 0, "nack_data");
    xfer(1'b0, 7'($urandom), 8'($urandom), 2, 3, -1, 0, "nack_last");
    xfer(1'b1, 7'($urandom), 8'($urandom), 2, 2, -1, 0, "nack_rstart");
    xfer(1'b0, 7'h50, 8'h40, 2,  -1,  1, 0, "al_reg");
    xfer(1'b1, 7'h50, 8'h50, 0,  -1, -1, 0, "rd_len0");
    xfer(1'b0, 7'($urandom), 8'($urandom), 15, -1, -1, 0, "wr15");
    xfer(1'b1, 7'($urandom), 8'($urandom), 15, -1, -1, 0, "rd15");
    for (int k = 0; k < 6; k++)
      xfer(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), $urandom_range(0, 15),
           -1, -1, 0, $sformatf("rnd%0d", k));

    // Reset while the first data byte command is outstanding.
    for (int i = 0; i < 16; i++) wq[i] = 8'($urandom);
    w_idx = 0; w_n = 3; ack_limit = 2; n_acked = 0; nack_idx = -1; al_idx = -1;
    log_q.delete();
    start_req(1'b0, 7'h22, 8'h33, 3);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (b.bc_write && n_acked == 2 && !b.bc_cmd_ack) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("rst_data_w.reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rst_data_w.after", {28'd0, cmd_on(), b.bc_ack_in, b.busy, b.req_ready}, {28'd0, 4'b0001});
    rst_n = 1'b1;
    w_n = 0;
    step();

    // Byte controller that never acknowledges the device-address command.
    ack_limit = 0; n_acked = 0;
    start_req(1'b0, 7'h11, 8'h01, 1);
    done_seen = 1'b0;
    on_cyc = 0;
    for (int c = 0; c < 60; c++) begin
      if (b.done) begin
        done_seen = 1'b1;
        break;
      end
      if (b.bc_start) on_cyc++;
      step();
    end
`ifdef I2C_SEQ_TIMEOUT_EN
    chk("timeout.done", 32'(done_seen), 32'd1);
    chk("timeout.status", 32'(b.status), 32'd3);
    chk("timeout.cmd_cycles", 32'(on_cyc), 32'd16);
    chk("timeout.cmd_dropped", 32'(cmd_on()), 32'd0);
`else
    chk("no_timeout.done", 32'(done_seen), 32'd0);
    chk("no_timeout.busy_cmd", {30'd0, b.busy, b.bc_start}, {30'd0, 2'b11});
    chk("no_timeout.cmd_cycles", 32'(on_cyc), 32'd60);
`endif
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_xfer_seq.md
Name: i2c_xfer_seq

Overview:
Transaction sequencer for the I2C byte controller behind the peripheral pads (scl/sda pad signals). It accepts one register-style transfer request: 7-bit device address, 8-bit register address, read/write and byte count. It then issues the full START/address/register/(repeated START)/data/STOP command sequence to the byte controller. Data moves through valid/ready streams, so software or a DMA never steps the byte controller command by command.

Parameters:
LEN_W, 4, width of req_len; maximum transfer is 2**LEN_W-1 data bytes
TIMEOUT_CYC, 65535, clk cycles allowed per byte command before timeout (used only with I2C_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  transfer request valid
req_ready  out  1  sequencer idle, request accepted when req_valid & req_ready
req_rnw  in  1  1=read, 0=write
req_dev_addr  in  7  I2C device address
req_reg_addr  in  8  register address byte
req_len  in  LEN_W  number of data bytes
wdata_valid / wdata_ready / wdata  in/out/in  1/1/8  write-data stream
rdata_valid / rdata_ready / rdata  out/in/out  1/1/8  read-data stream
done  out  1  one-cycle pulse at end of transfer
status  out  2  0=OK 1=NACK 2=ARB_LOST 3=TIMEOUT; valid with done, held until next accept
busy  out  1  transfer in progress
bc_start, bc_stop, bc_read, bc_write, bc_ack_in  out  1 each  byte-controller command bits
bc_din  out  8  byte to transmit
bc_cmd_ack  in  1  single-cycle command-complete pulse
bc_ack_out  in  1  slave ack bit received (0=ACK, 1=NACK)
bc_dout  in  8  received byte, valid with bc_cmd_ack
bc_al  in  1  arbitration lost pulse

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: all outputs 0 except req_ready=1; status=0. Reset mid-transfer aborts immediately; no STOP is issued; command bits are 0 on the next cycle.
- All outputs are registered. A command's bits stay asserted until the cycle bc_cmd_ack=1 and are cleared on the following edge. The next command can assert on that same edge.
- FSM states: IDLE, DEV_W, REG, WAIT_WD, DATA_W, RSTART, RD, RD_OUT, ERR_STOP, FIN.
- IDLE: on request accept, latch all req fields, busy=1, go to DEV_W.
- DEV_W: bc_start+bc_write, bc_din={dev,0}.
- REG: bc_write, bc_din=reg_addr. If latched len=0, also assert bc_stop, then go to FIN (rnw ignored).
- Write path: WAIT_WD asserts wdata_ready until the handshake and captures the byte. DATA_W then issues bc_write; the last byte adds bc_stop. No commands are issued while waiting for wdata.
- Read path: RSTART issues bc_start+bc_write with bc_din={dev,1}. RD issues bc_read, with bc_ack_in=0 on non-last bytes. The last byte uses bc_ack_in=1 plus bc_stop.
- RD_OUT: present bc_dout on rdata with rdata_valid until rdata_ready. The next bc_read is issued only after the handshake, so there is no read buffering beyond one byte.
- NACK: bc_ack_out=1 on any write command's bc_cmd_ack causes ERR_STOP. ERR_STOP issues bc_stop alone, then FIN with status=1. This applies to device, register and data bytes. For a data byte, remaining wdata is not consumed.
- Arbitration lost: bc_al=1 in any busy state drops command bits next cycle and goes to FIN with status=2. No STOP is issued. bc_al takes priority over a simultaneous bc_cmd_ack.
- FIN: done=1 for one cycle, busy=0, req_ready=1 on the next cycle.
- Byte counter: counts down from len, 0 means last done. The transfer ends exactly at len bytes with no wrap.
- bc_cmd_ack asserting while no command is outstanding is ignored.

Optional Feature:
I2C_SEQ_TIMEOUT_EN:
- Defined: a counter restarts at each command assertion. If it reaches TIMEOUT_CYC without bc_cmd_ack, command bits drop and the FSM goes to FIN with status=3 (no STOP). The counter is idle in WAIT_WD and RD_OUT.
- Undefined: no counter is present, the FSM waits indefinitely, and status 3 is never produced.

Test Plan:
1. Write, dev=0x50, reg=0x10, len=2, data A5,5A, model ACKs all -> commands START+W(0xA0), W(0x10), W(0xA5), W(0x5A)+STOP; done, status=0.
2. Read, dev=0x50, reg=0x20, len=3, model returns 11,22,33 -> START+W(0xA0), W(0x20), START+W(0xA1), R ack0, R ack0, R ack1+STOP; rdata 11,22,33; status=0. Repeat with rdata_ready low for 5 cycles: no bc_read issued during the stall.
3. Device-address NACK on write len=2 -> STOP-only command, done status=1, wdata_ready never asserted.
4. bc_al during REG command, coincident with bc_cmd_ack -> no further commands, no STOP, status=2, req_ready=1 after done.
5. len=0 read request -> START+W(dev,0), W(reg)+STOP only; status=0. Reset asserted during DATA_W -> all bc_* bits 0, busy=0, req_ready=1 the next cycle.
6. With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, model never acks DEV_W -> commands drop, done with status=3 after 16 cycles; without the macro, busy stays 1.
